mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory access controller sitting directly upstream of the two 8-bit byte-lane memories (high lane = odd bytes, low lane = even bytes). It accepts a CPU memory request (MIO.EN, R.W, DATA.SIZE, MAR, MDR), drives the shared lane address, the per-lane write data and the active-low per-lane write strobes, and returns a one-cycle ready pulse `r` together with the assembled 16-bit read word. Each access takes a fixed, parameterised latency, emulating LC-3b multi-cycle memory.

## Interface
- `LATENCY`, 4, wait cycles before the lane access completes; legal ≥1
- `ADDR_W`, 8, lane address width; the CPU byte address is `ADDR_W+1` bits
- `clk`  in  1  system clock; controller logic on rising edge, lanes sample on falling edge
- `reset`  in  1  asynchronous, active-low reset
- `mio_en`  in  1  request strobe; held high by the CPU until `r` is seen
- `r_w`  in  1  1 = write, 0 = read
- `data_size`  in  1  1 = word, 0 = byte
- `mar`  in  ADDR_W+1  byte address; bit 0 selects the lane for byte accesses
- `mdr_in`  in  16  write data; [15:8] to high lane, [7:0] to low lane. For byte stores the CPU replicates the byte into both halves.
- `high_out`, `low_out`  in  8 each  lane read data
- `lane_addr`  out  ADDR_W  shared lane address = `mar[ADDR_W:1]`
- `high_in`, `low_in`  out  8 each  lane write data
- `high_we_n`, `low_we_n`  out  1 each  active-low lane write enables
- `r`  out  1  ready, one-cycle pulse
- `mdr_out`  out  16  {high_out, low_out} captured at read completion

## Operation
- All outputs are registered.
- Reset values: `lane_addr`=0, `high_in`=`low_in`=0, both `we_n`=1, `r`=0, `mdr_out`=0, state IDLE, counter 0.
- **IDLE:** on `mio_en`=1, latch `mar`, `r_w`, `data_size`, `mdr_in`; drive `lane_addr` and lane data from the latched values; load counter = LATENCY-1; go to WAIT.
- **WAIT:** decrement the counter each cycle.
  - At counter==0 with a read: capture `mdr_out` <= {`high_out`,`low_out`} and go to DONE.
  - At counter==0 with a write: go to WRITE.
- **WRITE:** one cycle of write strobes, then DONE.
  - Word write: both `we_n` low.
  - Byte write with mar[0]=0: `low_we_n` only.
  - Byte write with mar[0]=1: `high_we_n` only.
- **DONE:** `r`=1 for this cycle only. Go to HOLD if `mio_en`=1, otherwise to IDLE.
- **HOLD:** wait until `mio_en`=0, then go to IDLE. This prevents a request still held high from causing a repeated access.
- Word accesses ignore mar[0].
- Byte reads return the full word; lane selection and sign/zero extension happen downstream.
- Request fields are latched in IDLE. Changes to `mar`/`mdr_in`/`r_w` mid-access are ignored.
- `mio_en` dropping mid-access does not abort the access; it completes and `r` still pulses.
- Asserting `reset` mid-access forces IDLE immediately and raises both `we_n` asynchronously, so no partial write strobe can reach a lane negedge after reset.
- `mdr_out` holds the last read value; writes leave it unchanged.

## Timing
- Edge 0 is the rising edge that sees `mio_en`=1 in IDLE.
- Read: `mdr_out` updates at edge LATENCY; `r` is high from edge LATENCY to edge LATENCY+1.
- Write: `we_n` is low from edge LATENCY to edge LATENCY+1, covering exactly one falling edge. `r` is high from edge LATENCY+1 to edge LATENCY+2.
- `lane_addr` and lane data are stable from edge 0 until the next request is accepted. At least one falling edge occurs in WAIT before the read capture.
- Minimum spacing between back-to-back accesses is DONE → IDLE → next accept, i.e. one idle cycle.

## Test plan
- **Word write then word read** (LATENCY=4): write mar=0x10, mdr_in=0xBEEF → `lane_addr`=0x08, both `we_n` low for exactly 1 cycle at edge 4, `r` at edge 5. Read mar=0x10 → `mdr_out`=0xBEEF, `r` at edge 4.
- **Byte writes:** mar=0x21, mdr_in=0x5A5A → only `high_we_n` pulses. Then mar=0x20, mdr_in=0x3C3C → only `low_we_n` pulses. A word read of 0x20 returns 0x5A3C.
- **HOLD:** hold `mio_en`=1 for 10 cycles after `r` → exactly one write strobe and one `r` pulse. After dropping `mio_en`, the controller returns to IDLE.
- **Mid-access changes:** change `mar` and `mdr_in` during WAIT and drop `mio_en` mid-access → the access uses the latched values and `r` still pulses once.
- **Reset:** assert `reset` during WRITE → `we_n` returns to 1 asynchronously, `r`=0, `mdr_out`=0, state IDLE, and no lane write occurs at the following falling edge.
- **LATENCY=1:** read completes with `r` at edge 1 and `mdr_out` correct. Also check that mar[0]=1 on a word read gives the same result as mar[0]=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Fixed-latency controller in front of two 8-bit byte-lane memories.
//            Latches a CPU request, drives lane address, data and active-low
//            strobes, and returns a one-cycle ready pulse with the read word.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic              data_size,
  input  logic [ADDR_W:0]   mar,
  input  logic [15:0]       mdr_in,
  input  logic [7:0]        high_out,
  input  logic [7:0]        low_out,
  output logic [ADDR_W-1:0] lane_addr,
  output logic [7:0]        high_in,
  output logic [7:0]        low_in,
  output logic              high_we_n,
  output logic              low_we_n,
  output logic              r,
  output logic [15:0]       mdr_out
);

  // Counter must hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int                 c_CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_wr;
  logic               r_word;
  logic               r_odd;
  logic               w_accept;
  logic               w_capture;
  logic               w_r_nxt;
  logic               w_high_we_n_nxt;
  logic               w_low_we_n_nxt;

  // State and wait counter; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic plus next values of the registered strobes and ready.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_accept        = 1'b0;
    w_capture       = 1'b0;
    w_r_nxt         = 1'b0;
    w_high_we_n_nxt = 1'b1;
    w_low_we_n_nxt  = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (mio_en) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_CNT_INIT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          if (r_wr) begin
            // Strobes are registered here so they are low for exactly the WRITE cycle.
            w_state_nxt     = S_WRITE;
            w_high_we_n_nxt = ~(r_word | r_odd);
            w_low_we_n_nxt  = ~(r_word | ~r_odd);
          end else begin
            w_capture   = 1'b1;
            w_r_nxt     = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WRITE: begin
        w_r_nxt     = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        // A request still held high must not start a second access.
        w_state_nxt = mio_en ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!mio_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch, lane drive, strobes, ready pulse and read capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr      <= 1'b0;
      r_word    <= 1'b0;
      r_odd     <= 1'b0;
      lane_addr <= '0;
      high_in   <= '0;
      low_in    <= '0;
      high_we_n <= 1'b1;
      low_we_n  <= 1'b1;
      r         <= 1'b0;
      mdr_out   <= '0;
    end else begin
      high_we_n <= w_high_we_n_nxt;
      low_we_n  <= w_low_we_n_nxt;
      r         <= w_r_nxt;
      if (w_accept) begin
        r_wr      <= r_w;
        r_word    <= data_size;
        r_odd     <= mar[0];
        lane_addr <= mar[ADDR_W:1];
        high_in   <= mdr_in[15:8];
        low_in    <= mdr_in[7:0];
      end
      if (w_capture) begin
        mdr_out <= {high_out, low_out};
      end
    end
  end

endmodule
`default_nettype wire
